validador_codigos_6bit: RTL and testbench

Streaming controller that sequences the team's 6-bit 22-code membership comparator over a stream of 6-bit line codes. It accepts codes over a valid/ready handshake and presents each code to the external combinational comparator. It registers the match result and forwards code plus error flag downstream. A code-lock FSM, with thresholds for acquiring and losing lock, and a saturating error counter sit alongside, feeding the decoder's status logic.

---
 rtl/validador_codigos_6bit_if.sv | 31 +++
 rtl/validador_codigos_6bit.sv | 187 ++++++++++++++++++
 tb/tb_validador_codigos_6bit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/validador_codigos_6bit_if.sv
// Handshake and status bundle for validador_codigos_6bit: input stream, comparator
// link, output stream and lock/error status.
interface validador_codigos_6bit_if #(
    parameter int ANCHO_ERRORES = 16
);
    logic [5:0]               Dato_In;
    logic                     Dato_Valido;
    logic                     Dato_Listo;
    logic [5:0]               Comp_Entrada;
    logic                     Comp_Salida;
    logic [5:0]               Dato_Out;
    logic                     Codigo_Error;
    logic                     Dato_Out_Valido;
    logic                     Dato_Out_Listo;
    logic                     Enganchado;
    logic [1:0]               Estado;
    logic [ANCHO_ERRORES-1:0] Cuenta_Errores;
    logic                     Limpiar_Errores;

    modport slave (
        input  Dato_In, Dato_Valido, Comp_Salida, Dato_Out_Listo, Limpiar_Errores,
        output Dato_Listo, Comp_Entrada, Dato_Out, Codigo_Error, Dato_Out_Valido,
               Enganchado, Estado, Cuenta_Errores
    );

    modport master (
        output Dato_In, Dato_Valido, Comp_Salida, Dato_Out_Listo, Limpiar_Errores,
        input  Dato_Listo, Comp_Entrada, Dato_Out, Codigo_Error, Dato_Out_Valido,
               Enganchado, Estado, Cuenta_Errores
    );
endinterface

// File: rtl/validador_codigos_6bit.sv
// Two-stage streaming controller around an external 22-code comparator, with code-lock
// FSM and saturating error counter. Optional macro DESCARTE_INVALIDOS_EN drops invalid words.
module validador_codigos_6bit #(
    parameter int CUENTA_ENGANCHE = 4,
    parameter int CUENTA_PERDIDA  = 3,
    parameter int ANCHO_ERRORES   = 16
) (
    input logic                    Reloj,
    input logic                    Reset_n,
    validador_codigos_6bit_if.slave bus
);
    typedef enum logic [1:0] {
        BUSCANDO    = 2'b00,
        VERIFICANDO = 2'b01,
        ENGANCHADO  = 2'b10,
        SOSPECHA    = 2'b11
    } estado_t;

    localparam logic [3:0]               ENGANCHE_C = 4'(CUENTA_ENGANCHE);
    localparam logic [3:0]               PERDIDA_C  = 4'(CUENTA_PERDIDA);
    localparam logic [ANCHO_ERRORES-1:0] MAX_C      = {ANCHO_ERRORES{1'b1}};
    localparam logic [ANCHO_ERRORES-1:0] UNO_C      = ANCHO_ERRORES'(1);

    logic                     e1_full_r;
    logic [5:0]               e1_code_r;
    logic                     e2_full_r;
    logic [5:0]               e2_code_r;
    logic                     err_r;
    estado_t                  estado_r;
    estado_t                  estado_nxt_s;
    logic [3:0]               run_r;
    logic [3:0]               run_nxt_s;
    logic [3:0]               run_inc_s;
    logic                     enganchado_r;
    logic [ANCHO_ERRORES-1:0] cuenta_r;
    logic [ANCHO_ERRORES-1:0] cuenta_nxt_s;

    logic acepta_s;
    logic mueve_s;
    logic valido_s;
    logic carga_e2_s;
    logic error_s;
    logic incrementa_s;

    assign valido_s  = bus.Comp_Salida;
    assign mueve_s   = e1_full_r & (~e2_full_r | bus.Dato_Out_Listo);
    assign acepta_s  = bus.Dato_Valido & bus.Dato_Listo;
    assign run_inc_s = run_r + 4'd1;

`ifdef DESCARTE_INVALIDOS_EN
    assign carga_e2_s = mueve_s & valido_s;
    assign error_s    = 1'b0;
`else
    assign carga_e2_s = mueve_s;
    assign error_s    = ~valido_s;
`endif

    // Two-stage pipeline: E1 feeds the comparator, E2 holds the evaluated word
    always_ff @(posedge Reloj or negedge Reset_n) begin
        if (!Reset_n) begin
            e1_full_r <= 1'b0;
            e1_code_r <= 6'd0;
            e2_full_r <= 1'b0;
            e2_code_r <= 6'd0;
            err_r     <= 1'b0;
        end else begin
            if (acepta_s) begin
                e1_full_r <= 1'b1;
                e1_code_r <= bus.Dato_In;
            end else if (mueve_s) begin
                e1_full_r <= 1'b0;
            end
            if (carga_e2_s) begin
                e2_full_r <= 1'b1;
                e2_code_r <= e1_code_r;
                err_r     <= error_s;
            end else if (bus.Dato_Out_Listo) begin
                e2_full_r <= 1'b0;
            end
        end
    end

    // Lock FSM next state; only an E1->E2 move counts as an evaluation
    always_comb begin
        estado_nxt_s = estado_r;
        run_nxt_s    = run_r;
        if (mueve_s) begin
            case (estado_r)
                BUSCANDO: begin
                    if (valido_s) begin
                        if (ENGANCHE_C == 4'd1) begin
                            estado_nxt_s = ENGANCHADO;
                            run_nxt_s    = 4'd0;
                        end else begin
                            estado_nxt_s = VERIFICANDO;
                            run_nxt_s    = 4'd1;
                        end
                    end else begin
                        estado_nxt_s = BUSCANDO;
                        run_nxt_s    = 4'd0;
                    end
                end
                VERIFICANDO: begin
                    if (!valido_s) begin
                        estado_nxt_s = BUSCANDO;
                        run_nxt_s    = 4'd0;
                    end else if (run_inc_s == ENGANCHE_C) begin
                        estado_nxt_s = ENGANCHADO;
                        run_nxt_s    = 4'd0;
                    end else begin
                        estado_nxt_s = VERIFICANDO;
                        run_nxt_s    = run_inc_s;
                    end
                end
                ENGANCHADO: begin
                    if (valido_s) begin
                        estado_nxt_s = ENGANCHADO;
                        run_nxt_s    = 4'd0;
                    end else if (PERDIDA_C == 4'd1) begin
                        estado_nxt_s = BUSCANDO;
                        run_nxt_s    = 4'd0;
                    end else begin
                        estado_nxt_s = SOSPECHA;
                        run_nxt_s    = 4'd1;
                    end
                end
                SOSPECHA: begin
                    if (valido_s) begin
                        estado_nxt_s = ENGANCHADO;
                        run_nxt_s    = 4'd0;
                    end else if (run_inc_s == PERDIDA_C) begin
                        estado_nxt_s = BUSCANDO;
                        run_nxt_s    = 4'd0;
                    end else begin
                        estado_nxt_s = SOSPECHA;
                        run_nxt_s    = run_inc_s;
                    end
                end
                default: begin
                    estado_nxt_s = BUSCANDO;
                    run_nxt_s    = 4'd0;
                end
            endcase
        end else begin
            estado_nxt_s = estado_r;
            run_nxt_s    = run_r;
        end
    end

    // Error counter: counts invalid evaluations made while locked (pre-update state); clear wins
    always_comb begin
        cuenta_nxt_s = cuenta_r;
        incrementa_s = mueve_s & ~valido_s &
                       ((estado_r == ENGANCHADO) | (estado_r == SOSPECHA));
        if (bus.Limpiar_Errores) begin
            cuenta_nxt_s = '0;
        end else if (incrementa_s && (cuenta_r != MAX_C)) begin
            cuenta_nxt_s = cuenta_r + UNO_C;
        end else begin
            cuenta_nxt_s = cuenta_r;
        end
    end

    // State, run counter, lock flag and error counter registers
    always_ff @(posedge Reloj or negedge Reset_n) begin
        if (!Reset_n) begin
            estado_r     <= BUSCANDO;
            run_r        <= 4'd0;
            enganchado_r <= 1'b0;
            cuenta_r     <= '0;
        end else begin
            estado_r     <= estado_nxt_s;
            run_r        <= run_nxt_s;
            enganchado_r <= (estado_nxt_s == ENGANCHADO) | (estado_nxt_s == SOSPECHA);
            cuenta_r     <= cuenta_nxt_s;
        end
    end

    assign bus.Dato_Listo      = ~e1_full_r | mueve_s;
    assign bus.Comp_Entrada    = e1_code_r;
    assign bus.Dato_Out        = e2_code_r;
    assign bus.Codigo_Error    = err_r;
    assign bus.Dato_Out_Valido = e2_full_r;
    assign bus.Enganchado      = enganchado_r;
    assign bus.Estado          = estado_r;
    assign bus.Cuenta_Errores  = cuenta_r;
endmodule

// File: tb/tb_validador_codigos_6bit.sv
// Self-checking bench: scoreboard on the output stream, table of lock-FSM vectors,
// hand sequences for latency, backpressure, mid-stream reset and counter saturation/clear.
module tb_validador_codigos_6bit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    validador_codigos_6bit_if #(.ANCHO_ERRORES(16)) bus ();
    validador_codigos_6bit_if #(.ANCHO_ERRORES(2))  sbus ();

    validador_codigos_6bit #(.CUENTA_ENGANCHE(4), .CUENTA_PERDIDA(3), .ANCHO_ERRORES(16))
        dut (.Reloj(clk), .Reset_n(rst_n), .bus(bus));
    validador_codigos_6bit #(.CUENTA_ENGANCHE(4), .CUENTA_PERDIDA(15), .ANCHO_ERRORES(2))
        dut_sat (.Reloj(clk), .Reset_n(rst_n), .bus(sbus));

    // 22-code set: 1..23 except 4
    function automatic logic codigo_valido(input logic [5:0] c);
        return (c >= 6'd1) && (c <= 6'd23) && (c != 6'd4);
    endfunction

    assign bus.Comp_Salida  = codigo_valido(bus.Comp_Entrada);
    assign sbus.Comp_Salida = codigo_valido(sbus.Comp_Entrada);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [5:0] code;
        logic       err;
    } sb_t;
    sb_t q[$];

    // Scoreboard: pop on output handshake, push on input handshake
    always @(negedge clk) begin
        sb_t e;
        if (rst_n) begin
            if (bus.Dato_Out_Valido && bus.Dato_Out_Listo) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual=%0h expected=none", bus.Dato_Out);
                end else begin
                    e = q.pop_front();
                    check("sb_code", 32'(bus.Dato_Out), 32'(e.code));
                    check("sb_err", 32'(bus.Codigo_Error), 32'(e.err));
                end
            end
            if (bus.Dato_Valido && bus.Dato_Listo) begin
`ifdef DESCARTE_INVALIDOS_EN
                if (codigo_valido(bus.Dato_In)) q.push_back('{code: bus.Dato_In, err: 1'b0});
`else
                q.push_back('{code: bus.Dato_In, err: ~codigo_valido(bus.Dato_In)});
`endif
            end
        end
    end

    typedef struct {
        logic [5:0]  code;
        logic [1:0]  estado;
        logic [15:0] cuenta;
    } vec_t;
    vec_t tabla[12];

    task automatic send_one(input logic [5:0] c);
        bus.Dato_In = c;
        bus.Dato_Valido = 1'b1;
        @(posedge clk); #1;
        bus.Dato_Valido = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_sat(input logic [5:0] c, input logic clr);
        sbus.Dato_In = c;
        sbus.Dato_Valido = 1'b1;
        @(posedge clk); #1;
        sbus.Dato_Valido = 1'b0;
        sbus.Limpiar_Errores = clr;
        @(posedge clk); #1;
        sbus.Limpiar_Errores = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] code;
        logic       acc;

        tabla[0]  = '{6'd1, 2'b01, 16'd0};
        tabla[1]  = '{6'd2, 2'b01, 16'd0};
        tabla[2]  = '{6'd3, 2'b01, 16'd0};
        tabla[3]  = '{6'd5, 2'b10, 16'd0};
        tabla[4]  = '{6'd0, 2'b11, 16'd1};
        tabla[5]  = '{6'd2, 2'b10, 16'd1};
        tabla[6]  = '{6'd4, 2'b11, 16'd2};
        tabla[7]  = '{6'd4, 2'b11, 16'd3};
        tabla[8]  = '{6'd4, 2'b00, 16'd4};
        tabla[9]  = '{6'd4, 2'b00, 16'd4};
        tabla[10] = '{6'd1, 2'b01, 16'd4};
        tabla[11] = '{6'd0, 2'b00, 16'd4};

        bus.Dato_In = 6'd0;  bus.Dato_Valido = 1'b0;
        bus.Dato_Out_Listo = 1'b1; bus.Limpiar_Errores = 1'b0;
        sbus.Dato_In = 6'd0; sbus.Dato_Valido = 1'b0;
        sbus.Dato_Out_Listo = 1'b1; sbus.Limpiar_Errores = 1'b0;

        do_reset();
        check("rst_listo", 32'(bus.Dato_Listo), 32'd1);
        check("rst_valido", 32'(bus.Dato_Out_Valido), 32'd0);
        check("rst_estado", 32'(bus.Estado), 32'd0);
        check("rst_cuenta", 32'(bus.Cuenta_Errores), 32'd0);
        check("rst_comp", 32'(bus.Comp_Entrada), 32'd0);

        // Lock acquire back-to-back, latency of two cycles
        bus.Dato_In = 6'd1; bus.Dato_Valido = 1'b1;
        @(posedge clk); #1;
        check("lat_not_yet", 32'(bus.Dato_Out_Valido), 32'd0);
        bus.Dato_In = 6'd2;
        @(posedge clk); #1;
        check("lat_valid", 32'(bus.Dato_Out_Valido), 32'd1);
        check("lat_out1", 32'(bus.Dato_Out), 32'd1);
        check("acq_estado01", 32'(bus.Estado), 32'd1);
        bus.Dato_In = 6'd3;
        @(posedge clk); #1;
        check("acq_out2", 32'(bus.Dato_Out), 32'd2);
        bus.Dato_In = 6'd5;
        @(posedge clk); #1;
        check("acq_out3", 32'(bus.Dato_Out), 32'd3);
        check("acq_still01", 32'(bus.Estado), 32'd1);
        bus.Dato_Valido = 1'b0;
        @(posedge clk); #1;
        check("acq_out5", 32'(bus.Dato_Out), 32'd5);
        check("acq_estado10", 32'(bus.Estado), 32'd2);
        check("acq_enganchado", 32'(bus.Enganchado), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        do_reset();
        for (int i = 0; i < 12; i++) begin
            send_one(tabla[i].code);
            check($sformatf("tab%0d_estado", i), 32'(bus.Estado), 32'(tabla[i].estado));
            check($sformatf("tab%0d_enganchado", i), 32'(bus.Enganchado), 32'(tabla[i].estado[1]));
            check($sformatf("tab%0d_cuenta", i), 32'(bus.Cuenta_Errores), 32'(tabla[i].cuenta));
        end

        // Backpressure: two words fill the pipe, then everything holds
        bus.Dato_Out_Listo = 1'b0;
        code = 6'd8;
        bus.Dato_In = code; bus.Dato_Valido = 1'b1;
        for (int cyc = 0; cyc < 11; cyc++) begin
            @(negedge clk);
            acc = bus.Dato_Valido & bus.Dato_Listo;
            if (cyc >= 2 && cyc < 5) begin
                check("bp_listo0", 32'(bus.Dato_Listo), 32'd0);
                check("bp_out_stable", 32'(bus.Dato_Out), 32'd8);
                check("bp_comp_stable", 32'(bus.Comp_Entrada), 32'd9);
            end
            @(posedge clk); #1;
            if (acc) begin
                code = code + 6'd1;
                bus.Dato_In = code;
            end
            if (cyc == 4) bus.Dato_Out_Listo = 1'b1;
        end
        bus.Dato_Valido = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_drained", 32'(q.size()), 32'd0);

        // Reset with both stages full discards the words
        bus.Dato_Out_Listo = 1'b0;
        bus.Dato_In = 6'd20; bus.Dato_Valido = 1'b1;
        @(posedge clk); #1;
        bus.Dato_In = 6'd21;
        @(posedge clk); #1;
        bus.Dato_Valido = 1'b0;
        check("mr_full_listo", 32'(bus.Dato_Listo), 32'd0);
        check("mr_full_valido", 32'(bus.Dato_Out_Valido), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mr_valido", 32'(bus.Dato_Out_Valido), 32'd0);
        check("mr_estado", 32'(bus.Estado), 32'd0);
        check("mr_cuenta", 32'(bus.Cuenta_Errores), 32'd0);
        check("mr_comp", 32'(bus.Comp_Entrada), 32'd0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.Dato_Out_Listo = 1'b1;
        @(posedge clk); #1;
        check("mr_listo", 32'(bus.Dato_Listo), 32'd1);
        check("mr_no_out", 32'(bus.Dato_Out_Valido), 32'd0);

        // 1,0,2 back-to-back: FSM sees code 0 in either build
        bus.Dato_In = 6'd1; bus.Dato_Valido = 1'b1;
        @(posedge clk); #1;
        bus.Dato_In = 6'd0;
        @(posedge clk); #1;
        bus.Dato_In = 6'd2;
        @(posedge clk); #1;
        bus.Dato_Valido = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("dsc_estado", 32'(bus.Estado), 32'd1);
        check("dsc_drained", 32'(q.size()), 32'd0);

        // Saturation and clear priority on the 2-bit counter instance
        send_sat(6'd1, 1'b0);
        send_sat(6'd2, 1'b0);
        send_sat(6'd3, 1'b0);
        send_sat(6'd5, 1'b0);
        check("sat_locked", 32'(sbus.Estado), 32'd2);
        for (int i = 0; i < 5; i++) send_sat(6'd0, 1'b0);
        check("sat_cuenta3", 32'(sbus.Cuenta_Errores), 32'd3);
        check("sat_sospecha", 32'(sbus.Estado), 32'd3);
        send_sat(6'd4, 1'b1);
        check("sat_clear_wins", 32'(sbus.Cuenta_Errores), 32'd0);
        send_sat(6'd0, 1'b0);
        check("sat_after_clear", 32'(sbus.Cuenta_Errores), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
